clk_stagger_seq: RTL

Controller that sequences the enables of N gated clock domains so they turn on or off one at a time, with a programmable gap between toggles. This limits simultaneous switching (di/dt) and skew-sensitive crossings. It sits beside the clock-skew/gating cells in the clock infrastructure and drives their enables. Software or a PMU issues one valid/ready request per sequence.

---
 rtl/clk_stagger_pkg.sv | 15 +
 rtl/clk_stagger_seq_if.sv | 31 +++
 rtl/clk_stagger_pick.sv | 32 +++
 rtl/clk_stagger_seq.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/clk_stagger_pkg.sv
// Shared definitions for the staggered clock-enable sequencer.
//   state_e : sequencer states
//   GAP_MIN : smallest effective gap between toggles (a configured 0 maps here)
package clk_stagger_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int GAP_MIN = 1;

endpackage

// File: rtl/clk_stagger_seq_if.sv
// Request/status bundle between a requester (software/PMU side) and the
// staggered clock-enable sequencer.
//   master : drives req_valid/req_on/req_mask/gap_cfg/abort, observes status
//   slave  : the sequencer; drives req_ready, clk_en, busy, done, done_aborted
interface clk_stagger_seq_if #(
    parameter int NUM_DOMAINS = 4,
    parameter int GAP_W       = 8
);

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_on;
    logic [NUM_DOMAINS-1:0] req_mask;
    logic [GAP_W-1:0]       gap_cfg;
    logic                   abort;
    logic [NUM_DOMAINS-1:0] clk_en;
    logic                   busy;
    logic                   done;
    logic                   done_aborted;

    modport master (
        output req_valid, req_on, req_mask, gap_cfg, abort,
        input  req_ready, clk_en, busy, done, done_aborted
    );

    modport slave (
        input  req_valid, req_on, req_mask, gap_cfg, abort,
        output req_ready, clk_en, busy, done, done_aborted
    );

endinterface

// File: rtl/clk_stagger_pick.sv
// Combinational N-bit priority picker.
//   vec : candidate bits
//   dir : 1 = pick lowest set bit, 0 = pick highest set bit
//   idx : index of the picked bit (0 when vec is empty)
//   any : vec has at least one bit set
module clk_stagger_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec,
    input  logic             dir,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = |vec;
        // The last match in scan order wins, so scanning downward yields the
        // lowest set bit and scanning upward yields the highest.
        if (dir) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/clk_stagger_seq.sv
// Staggered clock-enable sequencer. Turns the enables of NUM_DOMAINS gated
// clock domains on or off one domain per toggle, with a programmable number
// of clock edges between toggles, to limit simultaneous switching.
//   clock, reset_n : sole clock, asynchronous active-low reset
//   bus (slave)    : request handshake (req_valid/req_ready, req_on, req_mask,
//                    gap_cfg, abort) and status (clk_en, busy, done,
//                    done_aborted)
// Power-on enables ascend from bit 0; power-off enables descend from the top.
module clk_stagger_seq
    import clk_stagger_pkg::*;
#(
    parameter int                     NUM_DOMAINS = 4,
    parameter int                     GAP_W       = 8,
    parameter logic [NUM_DOMAINS-1:0] RESET_EN    = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    clk_stagger_seq_if.slave  bus
);

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    state_e                 state_q, state_d;
    logic                   on_q, on_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [GAP_W-1:0]       cnt_q, cnt_d;
    logic [NUM_DOMAINS-1:0] rem_q, rem_d;
    logic [NUM_DOMAINS-1:0] en_q, en_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;

    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic [NUM_DOMAINS-1:0] accept_rem;
    logic [GAP_W-1:0]       accept_gap;
    logic [NUM_DOMAINS-1:0] rem_after_step;

    clk_stagger_pick #(
        .N     (NUM_DOMAINS),
        .IDX_W (IDX_W)
    ) u_pick (
        .vec (rem_q),
        .dir (on_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Domains already in the target state drop out here so they cost no gap.
    assign accept_rem     = bus.req_mask & (en_q ^ {NUM_DOMAINS{bus.req_on}});
    assign accept_gap     = (bus.gap_cfg == '0) ? GAP_W'(GAP_MIN) : bus.gap_cfg;
    assign rem_after_step = rem_q & ~(NUM_DOMAINS'(1) << pick_idx);

    always_comb begin
        state_d   = state_q;
        on_d      = on_q;
        gap_d     = gap_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        en_d      = en_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    on_d  = bus.req_on;
                    gap_d = accept_gap;
                    rem_d = accept_rem;
                    if (accept_rem == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = STEP;
                    end
                end
            end

            STEP: begin
                if (bus.abort) begin
                    // Abort wins over this cycle's toggle.
                    state_d   = DONE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (pick_any) begin
                    en_d[pick_idx] = on_q;
                    rem_d          = rem_after_step;
                    if (rem_after_step == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (gap_q == GAP_W'(GAP_MIN)) begin
                        state_d = STEP;
                    end else begin
                        // The STEP->toggle edge is one of the G edges, so
                        // WAIT covers the remaining G-1.
                        cnt_d   = gap_q - GAP_W'(1);
                        state_d = WAIT;
                    end
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end

            WAIT: begin
                if (bus.abort) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (cnt_q == GAP_W'(1)) begin
                    state_d = STEP;
                end else begin
                    cnt_d = cnt_q - GAP_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            on_q      <= 1'b0;
            gap_q     <= GAP_W'(GAP_MIN);
            cnt_q     <= '0;
            rem_q     <= '0;
            en_q      <= RESET_EN;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            on_q      <= on_d;
            gap_q     <= gap_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            en_q      <= en_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.req_ready    = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.clk_en       = en_q;
    assign bus.done         = done_q;
    assign bus.done_aborted = aborted_q;

endmodule
